bus_comp_sched: RTL and testbench

Scheduler for the dual-bus frame comparator path. It accepts one CRC-checked 64-bit frame from each of two redundant bus channels and pairs them. It sequences the 48-bit payload comparison through its compare sub-module and reports a per-pair verdict. It also tracks consecutive mismatches and raises a sticky alarm for the supervising logic.

---
 rtl/bus_comp_pkg.sv | 24 ++
 rtl/bus_cmp_core.sv | 30 +++
 rtl/bus_comp_sched.sv | 193 +++++++++++++++++++
 tb/tb_bus_comp_sched.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus_comp_pkg.sv
// Shared types and default widths for the dual-bus frame comparator scheduler.
package bus_comp_pkg;

   localparam int DATA_W_DEF      = 64;
   localparam int CMP_W_DEF       = 48;
   localparam int TIMEOUT_CYC_DEF = 1023;
   localparam int ALARM_THR_DEF   = 3;
   localparam int CNT_W           = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      COMP   = 2'd2,
      REPORT = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      VERDICT_MATCH    = 2'b00,
      VERDICT_MISMATCH = 2'b01,
      VERDICT_CRC_ERR  = 2'b10,
      VERDICT_TIMEOUT  = 2'b11
   } verdict_t;

endpackage

// File: rtl/bus_cmp_core.sv
// Registered payload comparator: when enabled, latches whether any bit of the
// two captured payloads differs. The result is valid one cycle after enable.
module bus_cmp_core
   import bus_comp_pkg::*;
#(
   parameter int CMP_W = CMP_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_en,
   input  logic [CMP_W-1:0] i_a,
   input  logic [CMP_W-1:0] i_b,
   output logic             o_mismatch
);

   logic r_mismatch;

   // Latch the XOR-reduced difference of the payloads while enabled.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: state is updated with <= so every register samples pre-edge values.
      if (rst) begin
         r_mismatch <= 1'b0;
      end else if (i_en) begin
         r_mismatch <= |(i_a ^ i_b);
      end
   end

   assign o_mismatch = r_mismatch;

endmodule

// File: rtl/bus_comp_sched.sv
// Pairs one frame from each redundant bus channel, sequences the payload
// compare and reports a per-pair verdict, a consecutive-mismatch count and a
// sticky alarm. Optional partner-wait timeout: define COMP_TIMEOUT_EN.
module bus_comp_sched
   import bus_comp_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int CMP_W       = CMP_W_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
   parameter int ALARM_THR   = ALARM_THR_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid1,
   input  logic              valid2,
   input  logic [DATA_W-1:0] data1,
   input  logic [DATA_W-1:0] data2,
   input  logic              crcOk1,
   input  logic              crcOk2,
   output logic              rdy1,
   output logic              rdy2,
   input  logic              alarm_clr,
   output logic              result_valid,
   output logic [1:0]        result,
   output logic [CNT_W-1:0]  mismatch_cnt,
   output logic              alarm
);

   state_t             r_state;
   state_t             w_next;
   logic [CMP_W-1:0]   r_pay1;
   logic [CMP_W-1:0]   r_pay2;
   logic               r_full1;
   logic               r_full2;
   logic               r_crc1;
   logic               r_crc2;
   logic               r_to;
   logic [1:0]         r_result;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_alarm;
   logic               w_rdy1;
   logic               w_rdy2;
   logic               w_xfer1;
   logic               w_xfer2;
   logic               w_expire;
   logic               w_mis;
   logic               w_cmp_en;
   verdict_t           w_verdict;
   logic [CNT_W-1:0]   w_cnt_next;

   // The CRC field itself is checked upstream; only crcOk is consumed here.
   logic w_unused_crc;
   assign w_unused_crc = ^{data1[DATA_W-CMP_W-1:0], data2[DATA_W-CMP_W-1:0]};

   // A slot accepts a frame only when it is empty and the scheduler is collecting.
   assign w_rdy1   = !rst && ((r_state == IDLE) || ((r_state == WAIT) && !r_full1));
   assign w_rdy2   = !rst && ((r_state == IDLE) || ((r_state == WAIT) && !r_full2));
   assign w_xfer1  = valid1 && w_rdy1;
   assign w_xfer2  = valid2 && w_rdy2;
   assign w_cmp_en = (r_state == COMP);

`ifdef COMP_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TO_W-1:0] r_tcnt;

   // Count cycles spent waiting for the partner; zero whenever not waiting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tcnt <= '0;
      end else if (r_state != WAIT) begin
         r_tcnt <= '0;
      end else begin
         r_tcnt <= r_tcnt + 1'b1;
      end
   end

   // Expiry on the edge where the count reaches TIMEOUT_CYC; a partner on that edge wins.
   assign w_expire = (r_state == WAIT) && (r_tcnt == TO_W'(TIMEOUT_CYC - 1)) &&
                     !(w_xfer1 || w_xfer2);
`else
   localparam int unused_timeout_cyc = TIMEOUT_CYC;
   assign w_expire = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // Next-state logic.
   always_comb begin
      // NOTE: default assigned first so no path leaves w_next unassigned (no latch).
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_xfer1 && w_xfer2)      w_next = COMP;
            else if (w_xfer1 || w_xfer2) w_next = WAIT;
         end
         WAIT: begin
            if (w_xfer1 || w_xfer2) w_next = COMP;
            else if (w_expire)      w_next = REPORT;
         end
         COMP:    w_next = REPORT;
         REPORT:  w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Slot occupancy, CRC flags and timeout flag; slots free in REPORT or on expiry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_full1 <= 1'b0;
         r_full2 <= 1'b0;
         r_crc1  <= 1'b0;
         r_crc2  <= 1'b0;
         r_to    <= 1'b0;
      end else if (r_state == REPORT) begin
         r_full1 <= 1'b0;
         r_full2 <= 1'b0;
         r_to    <= 1'b0;
      end else if (w_expire) begin
         r_full1 <= 1'b0;
         r_full2 <= 1'b0;
         r_to    <= 1'b1;
      end else begin
         if (w_xfer1) begin
            r_full1 <= 1'b1;
            r_crc1  <= crcOk1;
         end
         if (w_xfer2) begin
            r_full2 <= 1'b1;
            r_crc2  <= crcOk2;
         end
      end
   end

   // Payload capture on transfer.
   always_ff @(posedge clk) begin
      // NOTE: payload storage has no reset; r_full* gates its use, so its content is don't-care.
      if (w_xfer1) r_pay1 <= data1[DATA_W-1 -: CMP_W];
      if (w_xfer2) r_pay2 <= data2[DATA_W-1 -: CMP_W];
   end

   bus_cmp_core #(
      .CMP_W (CMP_W)
   ) u_cmp (
      .clk        (clk),
      .rst        (rst),
      .i_en       (w_cmp_en),
      .i_a        (r_pay1),
      .i_b        (r_pay2),
      .o_mismatch (w_mis)
   );

   // Verdict priority: timeout, then CRC error, then compare result; next count.
   always_comb begin
      w_verdict  = VERDICT_MATCH;
      w_cnt_next = r_cnt;
      if (r_to)                   w_verdict = VERDICT_TIMEOUT;
      else if (!(r_crc1 && r_crc2)) w_verdict = VERDICT_CRC_ERR;
      else if (w_mis)             w_verdict = VERDICT_MISMATCH;
      case (w_verdict)
         VERDICT_MATCH:    w_cnt_next = '0;
         VERDICT_MISMATCH: if (r_cnt != {CNT_W{1'b1}}) w_cnt_next = r_cnt + 1'b1;
         default:          w_cnt_next = r_cnt;
      endcase
   end

   // Held verdict, mismatch counter and sticky alarm (set beats clear).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_result <= 2'b00;
         r_cnt    <= '0;
         r_alarm  <= 1'b0;
      end else begin
         if (r_state == REPORT) begin
            r_result <= w_verdict;
            r_cnt    <= w_cnt_next;
         end
         if ((r_state == REPORT) && (w_cnt_next >= CNT_W'(ALARM_THR))) r_alarm <= 1'b1;
         else if (alarm_clr)                                           r_alarm <= 1'b0;
      end
   end

   assign rdy1         = w_rdy1;
   assign rdy2         = w_rdy2;
   assign result_valid = (r_state == REPORT);
   assign result       = (r_state == REPORT) ? w_verdict : r_result;
   assign mismatch_cnt = r_cnt;
   assign alarm        = r_alarm;

endmodule

// File: tb/tb_bus_comp_sched.sv
// Directed bench for bus_comp_sched: pairing, verdicts, counter, alarm,
// reset during WAIT and (with COMP_TIMEOUT_EN) the partner timeout.
module tb_bus_comp_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid1 = 1'b0, valid2 = 1'b0;
   logic [63:0] data1 = '0, data2 = '0;
   logic        crcOk1 = 1'b0, crcOk2 = 1'b0;
   logic        rdy1, rdy2;
   logic        alarm_clr = 1'b0;
   logic        result_valid;
   logic [1:0]  result;
   logic [7:0]  mismatch_cnt;
   logic        alarm;

   int n_cmp = 0;
   int n_err = 0;

   localparam logic [63:0] D_A  = 64'h1234_5678_9ABC_0001;
   localparam logic [63:0] D_A2 = 64'h1234_5678_9ABC_FFFE;  // same payload, other CRC
   localparam logic [63:0] D_B  = 64'h1234_5678_9ABD_0001;  // payload bit 16 flipped

   bus_comp_sched #(
      .DATA_W      (64),
      .CMP_W       (48),
      .TIMEOUT_CYC (8),
      .ALARM_THR   (3)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .valid1       (valid1),
      .valid2       (valid2),
      .data1        (data1),
      .data2        (data2),
      .crcOk1       (crcOk1),
      .crcOk2       (crcOk2),
      .rdy1         (rdy1),
      .rdy2         (rdy2),
      .alarm_clr    (alarm_clr),
      .result_valid (result_valid),
      .result       (result),
      .mismatch_cnt (mismatch_cnt),
      .alarm        (alarm)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Both channels in the same cycle; checks latency and verdict.
   task automatic pair(input logic [63:0] d1, input logic ok1, input logic [63:0] d2,
                       input logic ok2, input string tag, input logic [1:0] exp_res);
      valid1 = 1'b1; data1 = d1; crcOk1 = ok1;
      valid2 = 1'b1; data2 = d2; crcOk2 = ok2;
      tick();
      valid1 = 1'b0; valid2 = 1'b0;
      check({tag, "_rv_comp"}, result_valid, 1'b0);
      tick();
      check({tag, "_rv"}, result_valid, 1'b1);
      check({tag, "_res"}, result, exp_res);
      tick();
   endtask

   initial begin
      // Reset values
      #2;
      check("rst_rdy1", rdy1, 1'b0);
      check("rst_rdy2", rdy2, 1'b0);
      check("rst_rv", result_valid, 1'b0);
      check("rst_res", result, 2'b00);
      check("rst_cnt", mismatch_cnt, 8'd0);
      check("rst_alarm", alarm, 1'b0);
      tick();
      tick();
      rst = 1'b0;
      #1;
      check("rel_rdy1", rdy1, 1'b1);
      check("rel_rdy2", rdy2, 1'b1);

      // Equal payload, different CRC bits
      pair(D_A, 1'b1, D_A2, 1'b1, "t1", 2'b00);
      check("t1_rv_after", result_valid, 1'b0);
      check("t1_res_hold", result, 2'b00);
      check("t1_cnt", mismatch_cnt, 8'd0);

      // Staggered arrival, bit 16 differs; a held valid1 in WAIT must be ignored
      valid1 = 1'b1; data1 = D_A; crcOk1 = 1'b1;
      tick();
      valid1 = 1'b0;
      check("t2_wait_rdy1", rdy1, 1'b0);
      check("t2_wait_rdy2", rdy2, 1'b1);
      valid1 = 1'b1; data1 = D_B;
      tick();
      tick();
      valid1 = 1'b0;
      tick();
      tick();
      check("t2_still_wait", result_valid, 1'b0);
      valid2 = 1'b1; data2 = D_B; crcOk2 = 1'b1;
      tick();
      valid2 = 1'b0;
      check("t2_rdy1_comp", rdy1, 1'b0);
      check("t2_rv_comp", result_valid, 1'b0);
      tick();
      check("t2_rv", result_valid, 1'b1);
      check("t2_res", result, 2'b01);
      tick();
      check("t2_cnt", mismatch_cnt, 8'd1);
      check("t2_res_hold", result, 2'b01);

      // Alarm build-up and clear
      pair(D_A, 1'b1, D_A, 1'b1, "t3m0", 2'b00);
      check("t3_cnt0", mismatch_cnt, 8'd0);
      pair(D_A, 1'b1, D_B, 1'b1, "t3x1", 2'b01);
      pair(D_B, 1'b1, D_A, 1'b1, "t3x2", 2'b01);
      check("t3_cnt2", mismatch_cnt, 8'd2);
      check("t3_alarm_lo", alarm, 1'b0);
      pair(D_A, 1'b1, D_B, 1'b1, "t3x3", 2'b01);
      check("t3_cnt3", mismatch_cnt, 8'd3);
      check("t3_alarm_hi", alarm, 1'b1);
      pair(D_A, 1'b1, D_A2, 1'b1, "t3m1", 2'b00);
      check("t3_cnt_clr", mismatch_cnt, 8'd0);
      check("t3_alarm_sticky", alarm, 1'b1);
      alarm_clr = 1'b1;
      tick();
      alarm_clr = 1'b0;
      check("t3_alarm_clr", alarm, 1'b0);

      // Set beats clear in the same cycle
      pair(D_A, 1'b1, D_B, 1'b1, "t3b1", 2'b01);
      pair(D_A, 1'b1, D_B, 1'b1, "t3b2", 2'b01);
      alarm_clr = 1'b1;
      pair(D_A, 1'b1, D_B, 1'b1, "t3b3", 2'b01);
      check("t3b_alarm_set_wins", alarm, 1'b1);
      alarm_clr = 1'b0;

      // Saturation: 3 + 255 mismatches caps at 255
      for (int i = 0; i < 255; i++) pair(D_B, 1'b1, D_A, 1'b1, "sat", 2'b01);
      check("sat_cnt", mismatch_cnt, 8'd255);

      // CRC errors leave the count unchanged
      pair(D_A, 1'b1, D_A, 1'b0, "t4a", 2'b10);
      check("t4a_cnt", mismatch_cnt, 8'd255);
      pair(D_A, 1'b0, D_B, 1'b1, "t4b", 2'b10);
      check("t4b_cnt", mismatch_cnt, 8'd255);
      check("t4_alarm", alarm, 1'b1);

      // Reset pulse while in WAIT
      valid1 = 1'b1; data1 = D_A; crcOk1 = 1'b1;
      tick();
      valid1 = 1'b0;
      check("t5_in_wait", rdy1, 1'b0);
      rst = 1'b1;
      #1;
      check("t5_rdy1", rdy1, 1'b0);
      check("t5_rdy2", rdy2, 1'b0);
      check("t5_rv", result_valid, 1'b0);
      check("t5_res", result, 2'b00);
      check("t5_cnt", mismatch_cnt, 8'd0);
      check("t5_alarm", alarm, 1'b0);
      tick();
      rst = 1'b0;
      #1;
      check("t5_rel_rdy1", rdy1, 1'b1);
      check("t5_rel_rdy2", rdy2, 1'b1);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t5_no_verdict", result_valid, 1'b0);
      end

`ifdef COMP_TIMEOUT_EN
      // Lone channel 1 frame times out after 8 WAIT cycles
      valid1 = 1'b1; data1 = D_A; crcOk1 = 1'b1;
      tick();
      valid1 = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      check("t6_pre_expiry", result_valid, 1'b0);
      tick();
      check("t6_rv", result_valid, 1'b1);
      check("t6_res", result, 2'b11);
      tick();
      check("t6_rdy1", rdy1, 1'b1);
      check("t6_rdy2", rdy2, 1'b1);
      check("t6_cnt", mismatch_cnt, 8'd0);
      // Partner on the expiry edge wins
      valid1 = 1'b1; data1 = D_A; crcOk1 = 1'b1;
      tick();
      valid1 = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      valid2 = 1'b1; data2 = D_A2; crcOk2 = 1'b1;
      tick();
      valid2 = 1'b0;
      check("t6b_rv_comp", result_valid, 1'b0);
      tick();
      check("t6b_rv", result_valid, 1'b1);
      check("t6b_res", result, 2'b00);
      tick();
`else
      // Without the timeout feature WAIT is unbounded
      valid1 = 1'b1; data1 = D_A; crcOk1 = 1'b1;
      tick();
      valid1 = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("t6_no_timeout", result_valid, 1'b0);
      end
      check("t6_still_wait", rdy1, 1'b0);
      valid2 = 1'b1; data2 = D_B; crcOk2 = 1'b1;
      tick();
      valid2 = 1'b0;
      tick();
      check("t6_rv", result_valid, 1'b1);
      check("t6_res", result, 2'b01);
      tick();
      check("t6_cnt", mismatch_cnt, 8'd1);
`endif

      // Back-to-back operation after all of the above
      pair(D_A, 1'b1, D_A, 1'b1, "t7", 2'b00);
      check("t7_cnt", mismatch_cnt, 8'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
